buffer_loader_4_16: RTL and testbench
=====================================

Name: buffer_loader_4_16

Overview:
- Fills the 4x16-byte window buffer from word-addressed memory.
- On start it fetches 32-bit words and presents each one on the buffer's load interface (ld, row, col, 32-bit data).
- Two modes: full load of all 16 words (4 rows x 4 column groups), or refill of one 4-byte column group across all 4 rows. Column refill supports the sliding window.
- Sits between the memory read port and the window buffer; the convolution controller drives it.

Parameters:
ADDR_W, 16, memory word-address width
ROW_STRIDE, 4, words between vertically adjacent image rows in memory

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  begin a load; sampled only in IDLE
mode  input  1  0 = full load (16 words), 1 = column refill (4 words)
col_sel  input  2  column group to refill when mode=1
base_addr  input  ADDR_W  word address of row 0 / column group 0
mem_rd  output  1  one-cycle read request
mem_addr  output  ADDR_W  read address, valid while mem_rd=1
mem_rdata  input  32  read data, valid when mem_valid=1
mem_valid  input  1  read data strobe, at least 1 cycle after mem_rd
ld  output  1  one-cycle buffer write strobe
row  output  2  buffer row for current word
col  output  2  buffer column group for current word
data  output  32  word to write; byte [31:24] goes to the lowest buffer index
busy  output  1  high from cycle after accepted start through DONE
done  output  1  one-cycle pulse after the last ld

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_rd=0, mem_addr=0, ld=0, row=0, col=0, data=0, busy=0, done=0.
  - Reset mid-operation aborts the load; no further ld or mem_rd after rst rises.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - busy=0.
  - start=1 latches base_addr, mode and col_sel.
  - Sets row=0; col=0 (mode 0) or col=col_sel (mode 1).
  - Next state REQ.
- REQ (1 cycle):
  - mem_rd=1.
  - mem_addr = base + row*ROW_STRIDE + col, computed modulo 2^ADDR_W.
  - Next state WAIT.
- WAIT:
  - Stays until mem_valid=1; then captures mem_rdata into data.
  - Next state WRITE.
  - mem_valid in any other state is ignored.
  - Exactly one outstanding request at a time.
- WRITE (1 cycle):
  - ld=1 with the current row, col and data.
  - Index advance, mode 0: col+1; on col=3, col wraps to 0 and row+1. Last word is row=3, col=3.
  - Index advance, mode 1: row+1, col held. Last word is row=3.
  - Last word: next state DONE; otherwise REQ.
- DONE (1 cycle):
  - done=1, busy=1.
  - Next state IDLE; busy drops the following cycle.
- start while not IDLE is ignored; it is not queued.
- Latency with mem_valid one cycle after mem_rd: 3 cycles per word.
  - Start sampled at edge 0 gives REQ in cycle 1.
  - Mode 0: last ld in cycle 48, done in cycle 49.
  - Mode 1: last ld in cycle 12, done in cycle 13.
  - Each extra wait cycle adds 1 cycle per word.
- row, col and data hold their values between ld pulses; ld is never high in two consecutive cycles.
- base_addr, mode and col_sel changing during busy have no effect.

Test Plan:
- Full load: ADDR_W=16, ROW_STRIDE=4, base=0x0010, memory returns 0xA000_0000|addr with 1-cycle latency -> mem_addr sequence 0x10..0x1F; 16 ld pulses with (row,col) (0,0),(0,1)..(3,3); data=0xA000_0010..0xA000_001F; done in cycle 49; busy low in cycle 50.
- Column refill: mode=1, col_sel=2, base=0x0020 -> addrs 0x22, 0x26, 0x2A, 0x2E; ld with row 0..3, col=2; done in cycle 13.
- Wait states: mem_valid delayed 3 cycles after each mem_rd, full load -> exactly one mem_rd per word; ld only the cycle after valid; done in cycle 81; spurious mem_valid pulses in WRITE/REQ do not change data.
- Busy/start: start pulsed at cycles 5 and 20 during a full load with base=0x0010, then base changed to 0x0100 -> single 16-word sequence from 0x0010; new start accepted only after busy=0.
- Address wrap: base=0xFFFE, ROW_STRIDE=4, mode 0 -> row 0 addrs 0xFFFE, 0xFFFF, 0x0000, 0x0001; row 1 starts 0x0002.
- Reset mid-load: rst=0 during WAIT of word 6, held 2 cycles -> all outputs 0 immediately; no ld or done afterwards; fresh start after rst=1 performs a complete 16-word load from row 0, col 0.

Source files
------------

// File: rtl/buffer_loader_4_16.sv
// Fills the 4x16-byte window buffer from word-addressed memory, one 32-bit word per ld.
// Latency: 3 cycles per word with 1-cycle memory response, plus 1 DONE cycle; each extra wait cycle adds 1 per word.
// Backpressure: one outstanding read; stalls in WAIT until mem_valid, start ignored while busy.
// Ports: start/mode/col_sel/base_addr from the convolution controller; mem_rd/mem_addr/mem_rdata/mem_valid
//   to the memory read port; ld/row/col/data to the window buffer load interface; busy/done status.
module buffer_loader_4_16 #(
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [1:0]        col_sel,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid,
  output logic              ld,
  output logic [1:0]        row,
  output logic [1:0]        col,
  output logic [31:0]       data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic              mode_q;
  logic              last_word;
  logic [ADDR_W-1:0] word_addr;

  // Column refill walks down the rows of one column group; full load walks
  // column groups first, then rows.
  assign last_word = mode_q ? (row == 2'd3) : ((row == 2'd3) && (col == 2'd3));

  // Address arithmetic is intentionally modulo 2^ADDR_W so a window near the
  // top of memory wraps to the bottom.
  assign word_addr = base_q + ADDR_W'(ROW_STRIDE) * ADDR_W'(row) + ADDR_W'(col);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      mode_q <= 1'b0;
      row    <= 2'd0;
      col    <= 2'd0;
      data   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            mode_q <= mode;
            row    <= 2'd0;
            col    <= mode ? col_sel : 2'd0;
          end
        end
        WAIT: begin
          if (mem_valid) begin
            data <= mem_rdata;
          end
        end
        WRITE: begin
          // Indices stay on the last word so row/col keep showing it after ld.
          if (!last_word) begin
            if (mode_q) begin
              row <= row + 2'd1;
            end else begin
              col <= col + 2'd1;
              if (col == 2'd3) begin
                row <= row + 2'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_addr = '0;
    ld       = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = REQ;
        end
      end
      REQ: begin
        mem_rd   = 1'b1;
        mem_addr = word_addr;
        state_d  = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        ld      = 1'b1;
        state_d = last_word ? DONE : REQ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_buffer_loader_4_16.sv
// Directed bench for buffer_loader_4_16: memory responder with programmable
// latency, output monitor, and per-run comparison against hand-derived sequences.
module tb_buffer_loader_4_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [1:0]  col_sel;
  logic [15:0] base_addr;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        ld;
  logic [1:0]  row;
  logic [1:0]  col;
  logic [31:0] data;
  logic        busy;
  logic        done;

  buffer_loader_4_16 #(.ADDR_W(16), .ROW_STRIDE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .col_sel   (col_sel),
    .base_addr (base_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .ld        (ld),
    .row       (row),
    .col       (col),
    .data      (data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int e0   = 0;   // edge count at which the start of the current run is sampled
  int lat  = 1;   // cycles from mem_rd to mem_valid
  bit spur = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: records every read request, every ld and the done/busy timing.
  logic [15:0] q_addr[$];
  logic [1:0]  q_row[$];
  logic [1:0]  q_col[$];
  logic [31:0] q_data[$];
  int          q_ldc[$];
  int          n_done    = 0;
  int          done_cyc  = 0;
  int          busy_last = 0;
  int          n_b2b     = 0;
  bit          prev_ld   = 1'b0;

  always @(negedge clk) begin
    if (mem_rd) q_addr.push_back(mem_addr);
    if (ld) begin
      q_row.push_back(row);
      q_col.push_back(col);
      q_data.push_back(data);
      q_ldc.push_back(cyc - e0 + 1);
    end
    if (ld && prev_ld) n_b2b <= n_b2b + 1;
    prev_ld <= ld;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc - e0 + 1;
    end
    if (busy) busy_last <= cyc - e0 + 1;
  end

  // Memory model: returns 0xA000_0000 | addr 'lat' cycles after mem_rd.
  // With spur set, also pulses mem_valid with junk data during REQ and WRITE.
  initial begin
    int          cnt;
    logic [15:0] ra;
    cnt       = 0;
    ra        = 16'h0;
    mem_valid = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_valid = 1'b1;
          mem_rdata = 32'hA000_0000 | {16'h0, ra};
        end
      end
      if (spur && (mem_rd || ld) && !mem_valid) begin
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      if (mem_rd) begin
        cnt = lat;
        ra  = mem_addr;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_mem_rd"},   32'(mem_rd),   32'h0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_ld"},       32'(ld),       32'h0);
    check({tag, "_row"},      32'(row),      32'h0);
    check({tag, "_col"},      32'(col),      32'h0);
    check({tag, "_data"},     data,          32'h0);
    check({tag, "_busy"},     32'(busy),     32'h0);
    check({tag, "_done"},     32'(done),     32'h0);
  endtask

  // One load: start sampled at edge 0; extra start pulses in cycles s1..s3;
  // inputs scrambled in cycle 3; optional reset asserted in cycle rst_at.
  task automatic run(input string tag, input logic [15:0] b, input logic m, input logic [1:0] cs,
                     input int l, input bit sp, input int s1, input int s2, input int s3,
                     input int rst_at, input int budget);
    int a0, l0, nd0, b2b0, n, per, rel, r, c;
    logic [15:0] ea;
    lat  = l;
    spur = sp;
    @(negedge clk);
    a0   = q_addr.size();
    l0   = q_ldc.size();
    nd0  = n_done;
    b2b0 = n_b2b;
    e0   = cyc + 1;
    base_addr = b;
    mode      = m;
    col_sel   = cs;
    start     = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      rel   = cyc - e0 + 1;
      start = (rel == s1) || (rel == s2) || (rel == s3);
      if (rel == 3) begin
        base_addr = 16'h0100;
        mode      = ~m;
        col_sel   = ~cs;
      end
      if (rst_at > 0 && rel == rst_at) begin
        rst = 1'b0;
        #1;
        check_zero({tag, "_rst"});
      end
      if (rst_at > 0 && rel == rst_at + 2) rst = 1'b1;
    end
    if (rst_at > 0) begin
      // Reset lands in WAIT of word 6: five words written, six requested.
      check({tag, "_n_ld"},   32'(q_ldc.size() - l0),  32'd5);
      check({tag, "_n_rd"},   32'(q_addr.size() - a0), 32'd6);
      check({tag, "_n_done"}, 32'(n_done - nd0),       32'd0);
    end else begin
      n   = m ? 4 : 16;
      per = l + 2;
      check({tag, "_n_ld"}, 32'(q_ldc.size() - l0),  32'(n));
      check({tag, "_n_rd"}, 32'(q_addr.size() - a0), 32'(n));
      for (int i = 0; i < n; i++) begin
        r  = m ? i : i / 4;
        c  = m ? int'(cs) : i % 4;
        ea = b + 16'(r * 4 + c);
        if (a0 + i < q_addr.size())
          check($sformatf("%s_addr%0d", tag, i), 32'(q_addr[a0 + i]), 32'(ea));
        if (l0 + i < q_ldc.size()) begin
          check($sformatf("%s_row%0d", tag, i),  32'(q_row[l0 + i]), 32'(r));
          check($sformatf("%s_col%0d", tag, i),  32'(q_col[l0 + i]), 32'(c));
          check($sformatf("%s_data%0d", tag, i), q_data[l0 + i], 32'hA000_0000 | {16'h0, ea});
          check($sformatf("%s_ldcyc%0d", tag, i), 32'(q_ldc[l0 + i]), 32'((i + 1) * per));
        end
      end
      check({tag, "_n_done"},    32'(n_done - nd0), 32'd1);
      check({tag, "_done_cyc"},  32'(done_cyc),     32'(n * per + 1));
      check({tag, "_busy_last"}, 32'(busy_last),    32'(n * per + 1));
      check({tag, "_ld_b2b"},    32'(n_b2b - b2b0), 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    col_sel   = 2'd0;
    base_addr = 16'h0;
    #1;
    check_zero("por");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run("full",   16'h0010, 1'b0, 2'd0, 1, 1'b0, -1, -1, -1, -1, 60);
    run("colref", 16'h0020, 1'b1, 2'd2, 1, 1'b0, -1, -1, -1, -1, 20);
    run("wait3",  16'h0010, 1'b0, 2'd0, 3, 1'b1, -1, -1, -1, -1, 95);
    run("busy",   16'h0010, 1'b0, 2'd0, 1, 1'b0,  5, 20, 49, -1, 65);
    run("wrap",   16'hFFFE, 1'b0, 2'd0, 1, 1'b0, -1, -1, -1, -1, 60);
    run("abort",  16'h0010, 1'b0, 2'd0, 1, 1'b0, -1, -1, -1, 17, 60);
    run("fresh",  16'h0040, 1'b0, 2'd0, 1, 1'b0, -1, -1, -1, -1, 60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
